// File: rtl/vram_pkg.sv
// Shared types for the dual-client video RAM: access grant and clear-engine state.
package vram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CLR  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_SCAN = 2'd3
    } grant_e;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/vram_if.sv
// Client-side bus of vram_dp: CPU access port, scanout stream and clear control.
interface vram_if import vram_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned LANES      = 1
);
    localparam int unsigned W = BYTE_W * LANES;

    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [LANES-1:0]      a_be;
    logic [W-1:0]          a_wdata;
    logic                  a_ready;
    logic                  a_rvalid;
    logic [W-1:0]          a_rdata;

    logic                  s_start;
    logic [ADDR_WIDTH-1:0] s_base;
    logic [ADDR_WIDTH:0]   s_count;
    logic                  s_valid;
    logic                  s_ready;
    logic [W-1:0]          s_data;
    logic                  s_last;
    logic                  s_busy;

    logic                  clr_start;
    logic [W-1:0]          clr_value;
    logic                  clr_busy;

    modport master (
        output a_req, a_we, a_addr, a_be, a_wdata,
        output s_start, s_base, s_count, s_ready,
        output clr_start, clr_value,
        input  a_ready, a_rvalid, a_rdata,
        input  s_valid, s_data, s_last, s_busy,
        input  clr_busy
    );

    modport slave (
        input  a_req, a_we, a_addr, a_be, a_wdata,
        input  s_start, s_base, s_count, s_ready,
        input  clr_start, clr_value,
        output a_ready, a_rvalid, a_rdata,
        output s_valid, s_data, s_last, s_busy,
        output clr_busy
    );

endinterface

// File: rtl/vram_dp_sync_fifo.sv
// Shift-register FIFO whose head entry and valid flag are flops, with synchronous flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_ready,
    output logic                           rd_valid,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q   [DEPTH];
    logic [WIDTH-1:0] shifted [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    wr_idx;
    logic             valid_q;
    logic             pop;

    always_comb begin
        pop     = valid_q & rd_ready;
        wr_idx  = cnt_q - CW'(pop);
        cnt_nxt = cnt_q + CW'(wr_en) - CW'(pop);
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            shifted[i] = mem_q[i + 1];
        end
        shifted[DEPTH-1] = mem_q[DEPTH-1];
    end

    // Entry 0 is always the head, so a pop shifts everything down one slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            valid_q <= (cnt_nxt != '0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wr_en && (wr_idx == CW'(i))) begin
                    mem_q[i] <= wr_data;
                end else if (pop) begin
                    mem_q[i] <= shifted[i];
                end
            end
        end
    end

    assign rd_valid = valid_q;
    assign rd_data  = mem_q[0];
    assign level    = cnt_q;

endmodule

// File: rtl/vram_dp.sv
// Dual-client video RAM: one access per cycle, arbitrated clear > CPU > scanout prefetch.
module vram_dp import vram_pkg::*; #(
    parameter int unsigned ADDR_WIDTH     = 20,
    parameter int unsigned LANES          = 1,
    parameter int unsigned SCAN_DEPTH     = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    vram_if.slave  bus
);
    localparam int unsigned W     = BYTE_W * LANES;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LVL_W = $clog2(SCAN_DEPTH + 1);
    localparam int unsigned RW    = ADDR_WIDTH + 1;

    logic [W-1:0]          mem [DEPTH];

    clr_state_e            clr_state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [W-1:0]          clr_val;
    logic                  clr_busy;

    grant_e                gnt;
    logic                  scan_elig;
    logic [ADDR_WIDTH-1:0] scan_addr;
    logic [RW-1:0]         scan_rem;
    logic                  s_busy_q;

    logic                  a_rvalid_q;
    logic [W-1:0]          a_rdata_q;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [W-1:0]          wr_data;
    logic [LANES-1:0]      wr_be;

    logic [W:0]            fifo_din;
    logic [W:0]            fifo_dout;
    logic                  fifo_valid;
    logic [LVL_W-1:0]      fifo_level;

    assign clr_busy = (clr_state == CLR_RUN);

    // A restart this cycle suppresses the fetch so no stale word lands after the flush.
    always_comb begin
        scan_elig = (scan_rem != '0) && (fifo_level < LVL_W'(SCAN_DEPTH)) && !bus.s_start;
        gnt       = GNT_NONE;
        if (clr_busy) begin
            gnt = GNT_CLR;
        end else if (bus.a_req) begin
            gnt = GNT_CPU;
        end else if (scan_elig) begin
            gnt = GNT_SCAN;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.a_addr;
        wr_data = bus.a_wdata;
        wr_be   = bus.a_be;
        if (gnt == GNT_CLR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = clr_val;
            wr_be   = '1;
        end else if (gnt == GNT_CPU) begin
            wr_en   = bus.a_we;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (wr_be[l]) begin
                    mem[wr_addr][l*BYTE_W +: BYTE_W] <= wr_data[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_state <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
            clr_addr  <= '0;
            clr_val   <= '0;
        end else begin
            case (clr_state)
                CLR_IDLE: begin
                    if (bus.clr_start) begin
                        clr_state <= CLR_RUN;
                        clr_addr  <= '0;
                        clr_val   <= bus.clr_value;
                    end
                end
                CLR_RUN: begin
                    clr_addr <= clr_addr + ADDR_WIDTH'(1);
                    if (clr_addr == '1) begin
                        clr_state <= CLR_IDLE;
                    end
                end
                default: clr_state <= CLR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= (gnt == GNT_CPU) && !bus.a_we;
            if ((gnt == GNT_CPU) && !bus.a_we) begin
                a_rdata_q <= mem[bus.a_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_addr <= '0;
            scan_rem  <= '0;
            s_busy_q  <= 1'b0;
        end else if (bus.s_start) begin
            scan_addr <= bus.s_base;
            scan_rem  <= bus.s_count;
            s_busy_q  <= (bus.s_count != '0);
        end else begin
            if (gnt == GNT_SCAN) begin
                scan_addr <= scan_addr + ADDR_WIDTH'(1);
                scan_rem  <= scan_rem - RW'(1);
            end
            if (fifo_valid && bus.s_ready && fifo_dout[W]) begin
                s_busy_q <= 1'b0;
            end
        end
    end

    // Fetched word carries its own end-of-run flag through the prefetch queue.
    assign fifo_din = {(scan_rem == RW'(1)), mem[scan_addr]};

    sync_fifo #(
        .WIDTH (W + 1),
        .DEPTH (SCAN_DEPTH)
    ) u_scan_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.s_start),
        .wr_en    (gnt == GNT_SCAN),
        .wr_data  (fifo_din),
        .rd_ready (bus.s_ready),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_dout),
        .level    (fifo_level)
    );

    assign bus.a_ready  = !clr_busy;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.s_valid  = fifo_valid;
    assign bus.s_data   = fifo_dout[W-1:0];
    assign bus.s_last   = fifo_valid & fifo_dout[W];
    assign bus.s_busy   = s_busy_q;
    assign bus.clr_busy = clr_busy;

endmodule

// File: tb/tb_vram_dp.sv
// Directed bench for vram_dp: clear engine, CPU byte-lane access, scanout streaming and reset.
module tb_vram_dp;
    localparam int unsigned AW = 8;
    localparam int unsigned LN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_if #(.ADDR_WIDTH(AW), .LANES(LN)) bus();

    vram_dp #(
        .ADDR_WIDTH     (AW),
        .LANES          (LN),
        .SCAN_DEPTH     (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] got_data [$];
    logic        got_last [$];
    int          stall_err;
    logic        busy_at_last;
    logic        busy_after_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.clr_busy && n < 400);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [1:0] be, input logic [15:0] d);
        bus.a_req   = 1'b1;
        bus.a_we    = 1'b1;
        bus.a_addr  = a;
        bus.a_be    = be;
        bus.a_wdata = d;
        tick();
        bus.a_req   = 1'b0;
        bus.a_we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic v, output logic [15:0] d);
        bus.a_req  = 1'b1;
        bus.a_we   = 1'b0;
        bus.a_addr = a;
        tick();
        bus.a_req  = 1'b0;
        v = bus.a_rvalid;
        d = bus.a_rdata;
    endtask

    // mode 0: s_ready held high; mode 1: s_ready toggles and CPU writes 0x40 on even cycles
    task automatic collect(input int ncyc, input int mode, output logic [15:0] last_cpu);
        logic [15:0] held = '0;
        logic        was_stalled = 1'b0;
        logic        pend = 1'b0;
        got_data.delete();
        got_last.delete();
        stall_err       = 0;
        busy_at_last    = 1'b0;
        busy_after_last = 1'b1;
        last_cpu        = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (mode == 1) begin
                bus.s_ready = (c % 2 == 1);
                bus.a_req   = (c % 2 == 0);
                bus.a_we    = 1'b1;
                bus.a_addr  = 8'h40;
                bus.a_be    = 2'b11;
                bus.a_wdata = 16'(16'h4000 + c);
                if (c % 2 == 0) last_cpu = 16'(16'h4000 + c);
            end else begin
                bus.s_ready = 1'b1;
                bus.a_req   = 1'b0;
            end
            if (pend) begin
                busy_after_last = bus.s_busy;
                pend = 1'b0;
            end
            if (was_stalled && (!bus.s_valid || bus.s_data !== held)) stall_err++;
            if (bus.s_valid && bus.s_ready) begin
                got_data.push_back(bus.s_data);
                got_last.push_back(bus.s_last);
                if (bus.s_last) begin
                    busy_at_last = bus.s_busy;
                    pend = 1'b1;
                end
            end
            was_stalled = bus.s_valid && !bus.s_ready;
            held        = bus.s_data;
            tick();
        end
        bus.a_req = 1'b0;
        bus.a_we  = 1'b0;
    endtask

    task automatic scan_start(input logic [7:0] base, input logic [8:0] cnt);
        bus.s_start = 1'b1;
        bus.s_base  = base;
        bus.s_count = cnt;
        tick();
        bus.s_start = 1'b0;
    endtask

    initial begin
        int          n;
        logic        v;
        logic [15:0] d;
        logic [15:0] last_cpu;
        logic [15:0] exp5 [4];

        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_be = '0; bus.a_wdata = '0;
        bus.s_start = 1'b0; bus.s_base = '0; bus.s_count = '0; bus.s_ready = 1'b0;
        bus.clr_start = 1'b0; bus.clr_value = '0;

        repeat (2) tick();
        check_eq("rst_clr_busy", 32'(bus.clr_busy), 32'd1);
        check_eq("rst_a_ready",  32'(bus.a_ready),  32'd0);
        check_eq("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        check_eq("rst_s_valid",  32'(bus.s_valid),  32'd0);
        check_eq("rst_s_busy",   32'(bus.s_busy),   32'd0);

        // Power-on clear
        rst = 1'b0;
        wait_clear(n);
        check_eq("por_clear_cycles", 32'(n), 32'd256);
        check_eq("por_a_ready", 32'(bus.a_ready), 32'd1);
        cpu_read(8'h00, v, d);
        check_eq("rd00_valid", 32'(v), 32'd1);
        check_eq("rd00_data",  32'(d), 32'h0000);
        cpu_read(8'hFF, v, d);
        check_eq("rdFF_data",  32'(d), 32'h0000);
        tick();
        check_eq("rvalid_pulse", 32'(bus.a_rvalid), 32'd0);

        // Byte-lane writes
        cpu_write(8'h05, 2'b11, 16'hABCD);
        cpu_write(8'h05, 2'b01, 16'h3412);
        cpu_read(8'h05, v, d);
        check_eq("lane_write", 32'(d), 32'hAB12);
        cpu_write(8'h05, 2'b00, 16'hFFFF);
        cpu_read(8'h05, v, d);
        check_eq("be0_noop", 32'(d), 32'hAB12);

        // Scanout with address wrap
        cpu_write(8'hFE, 2'b11, 16'hFEFE);
        cpu_write(8'hFF, 2'b11, 16'hFFFF);
        cpu_write(8'h00, 2'b11, 16'h0000);
        cpu_write(8'h01, 2'b11, 16'h0101);
        bus.s_ready = 1'b1;
        scan_start(8'hFE, 9'd4);
        check_eq("t5_busy_rise", 32'(bus.s_busy), 32'd1);
        collect(12, 0, last_cpu);
        exp5[0] = 16'hFEFE; exp5[1] = 16'hFFFF; exp5[2] = 16'h0000; exp5[3] = 16'h0101;
        check_eq("t5_beats", 32'(got_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            check_eq($sformatf("t5_data%0d", i), 32'(got_data[i]), 32'(exp5[i]));
            check_eq($sformatf("t5_last%0d", i), 32'(got_last[i]), (i == 3) ? 32'd1 : 32'd0);
        end
        check_eq("t5_busy_at_last",    32'(busy_at_last),    32'd1);
        check_eq("t5_busy_after_last", 32'(busy_after_last), 32'd0);

        // Scanout under backpressure with interleaved CPU writes
        for (int i = 0; i < 8; i++) cpu_write(8'(8'h10 + i), 2'b11, 16'(16'hC000 + i));
        scan_start(8'h10, 9'd8);
        collect(60, 1, last_cpu);
        check_eq("t6_beats", 32'(got_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            check_eq($sformatf("t6_data%0d", i), 32'(got_data[i]), 32'(16'hC000 + i));
            check_eq($sformatf("t6_last%0d", i), 32'(got_last[i]), (i == 7) ? 32'd1 : 32'd0);
        end
        check_eq("t6_stall_stable", 32'(stall_err), 32'd0);
        cpu_read(8'h40, v, d);
        check_eq("t6_cpu_data", 32'(d), 32'(last_cpu));

        // Restart mid-run
        bus.s_ready = 1'b0;
        scan_start(8'h10, 9'd8);
        repeat (8) tick();
        check_eq("t7_stalled_valid", 32'(bus.s_valid), 32'd1);
        check_eq("t7_stalled_data",  32'(bus.s_data),  32'hC000);
        scan_start(8'hFE, 9'd2);
        check_eq("t7_flushed", 32'(bus.s_valid), 32'd0);
        collect(12, 0, last_cpu);
        check_eq("t7_beats", 32'(got_data.size()), 32'd2);
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            check_eq($sformatf("t7_data%0d", i), 32'(got_data[i]), (i == 0) ? 32'hFEFE : 32'hFFFF);
            check_eq($sformatf("t7_last%0d", i), 32'(got_last[i]), (i == 1) ? 32'd1 : 32'd0);
        end

        // Zero-length run
        scan_start(8'h20, 9'd0);
        check_eq("t7_zero_busy", 32'(bus.s_busy), 32'd0);
        collect(10, 0, last_cpu);
        check_eq("t7_zero_beats", 32'(got_data.size()), 32'd0);

        // Clear during scan, then asynchronous reset mid-clear
        scan_start(8'h00, 9'd200);
        repeat (5) tick();
        bus.clr_start = 1'b1;
        bus.clr_value = 16'h5A5A;
        tick();
        bus.clr_start = 1'b0;
        check_eq("t8_clr_busy",  32'(bus.clr_busy), 32'd1);
        check_eq("t8_a_ready",   32'(bus.a_ready),  32'd0);
        check_eq("t8_scan_busy", 32'(bus.s_busy),   32'd1);
        repeat (20) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("t8_rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        check_eq("t8_rst_a_rdata",  32'(bus.a_rdata),  32'd0);
        check_eq("t8_rst_s_valid",  32'(bus.s_valid),  32'd0);
        check_eq("t8_rst_s_data",   32'(bus.s_data),   32'd0);
        check_eq("t8_rst_s_last",   32'(bus.s_last),   32'd0);
        check_eq("t8_rst_s_busy",   32'(bus.s_busy),   32'd0);
        check_eq("t8_rst_clr_busy", 32'(bus.clr_busy), 32'd1);
        check_eq("t8_rst_a_ready",  32'(bus.a_ready),  32'd0);
        bus.s_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        wait_clear(n);
        check_eq("t8_clear_cycles", 32'(n), 32'd256);
        cpu_read(8'h05, v, d);
        check_eq("t8_rd05", 32'(d), 32'h0000);
        cpu_read(8'hFF, v, d);
        check_eq("t8_rdFF", 32'(d), 32'h0000);
        check_eq("t8_s_busy_idle", 32'(bus.s_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_dp.md
# vram_dp

Dual-client video RAM, successor to the single-port byte VRAM. Generalises data width (byte lanes with per-lane write enables) and adds a streaming scanout read port with a prefetch FIFO, plus a hardware clear engine replacing the per-entry reset loop. One physical access per cycle, arbitrated clear > CPU > scanout. Sits between the CPU bus adapter and the display controller.

## Interface
- ADDR_WIDTH, 20: word address width; depth = 2**ADDR_WIDTH words.
- LANES, 1: byte lanes per word; word width W = 8*LANES.
- SCAN_DEPTH, 4: scanout prefetch FIFO depth (power of two, ≥2).
- CLEAR_ON_RESET, 1: when 1, clear engine starts automatically after reset, value 0.
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  reset; asynchronous, active-high.
- a_req  in  1  CPU access request.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  CPU word address.
- a_be  in  LANES  write byte enables.
- a_wdata  in  W  write data.
- a_ready  out  1  request accepted this cycle (a_req & a_ready).
- a_rvalid  out  1  read data valid (one-cycle pulse).
- a_rdata  out  W  read data.
- s_start  in  1  start scanout pulse.
- s_base  in  ADDR_WIDTH  first scanout word address.
- s_count  in  ADDR_WIDTH+1  words to stream.
- s_valid / s_ready  out / in  1  stream handshake.
- s_data  out  W  stream word.
- s_last  out  1  final word of the run.
- s_busy  out  1  run active (words outstanding).
- clr_start  in  1  start clear pulse.
- clr_value  in  W  fill value, latched at clr_start.
- clr_busy  out  1  clear in progress.

## Operation
- Grant per cycle: clear engine if clr_busy; else CPU if a_req; else scan fetch if eligible; else idle.
- a_ready = !clr_busy (combinational). CPU never stalls outside clear.
- Write: lanes with a_be[i]=1 updated; a_be=0 is a legal no-op.
- Clear FSM: IDLE -> RUN (on clr_start or post-reset when CLEAR_ON_RESET) -> IDLE after writing word 2**ADDR_WIDTH-1; one word per cycle, address 0 upward, all lanes. clr_start during RUN ignored.
- Scan: s_start latches base/count, flushes FIFO and cancels in-flight fetch (restart-while-busy allowed). s_count=0: no beats, s_busy stays 0. Fetch eligible when remaining>0 and FIFO occupancy + in-flight < SCAN_DEPTH. Address increments mod 2**ADDR_WIDTH (wraps to 0).
- s_last asserted with the word whose fetch consumed remaining to 0; s_busy falls on the cycle after that word's s_valid&s_ready.
- s_data held stable while s_valid & !s_ready.
- Scanout reads see all writes granted in earlier cycles.
- Reset mid-operation: FSMs to IDLE, FIFO flushed, pending reads dropped; memory contents not reset (only the clear engine writes them).

## Timing
- CPU read accepted at posedge N -> a_rvalid=1, a_rdata at posedge N+1.
- CPU write committed at posedge N; read of same address accepted at N+1 returns new data.
- Scan fetch granted at N -> word in FIFO at N+1 -> s_valid earliest at N+1. s_start at N -> first fetch at N+1. Sustained 1 word/cycle when CPU idle and s_ready=1.
- Clear: 2**ADDR_WIDTH cycles; clr_busy rises the cycle after clr_start, falls after last write.
- Reset values: a_rvalid 0, a_rdata 0, s_valid 0, s_data 0, s_last 0, s_busy 0, clr_busy = CLEAR_ON_RESET (a_ready = !CLEAR_ON_RESET).

## Structure
- Package vram_pkg: grant enum (GNT_NONE, GNT_CLR, GNT_CPU, GNT_SCAN), clear FSM state enum (CLR_IDLE, CLR_RUN).
- Sub-module sync_fifo (parametrised width/depth, flush input) for scanout prefetch; arbiter, clear FSM and memory array in vram_dp.

## Test plan
- ADDR_WIDTH=8, LANES=2, CLEAR_ON_RESET=1: release rst -> clr_busy high 256 cycles, a_ready low; then read 0x00 and 0xFF -> 0x0000.
- Write 0x12 to addr 5 with be=2'b01 over 0xABCD -> read addr 5 returns 0xAB12 one cycle after accept.
- s_base=0xFE, s_count=4, words preloaded i*0x0101 -> stream 0xFEFE,0xFFFF,0x0000,0x0101, s_last on 4th, s_busy low after.
- Scan active with s_ready toggling, CPU writes addr 0x40 every other cycle -> no beat lost/duplicated, order preserved, s_data stable while stalled.
- s_start mid-run with s_count=2 at new base -> old words flushed, exactly 2 new beats; s_count=0 -> no s_valid.
- clr_start(0x5A5A) during scan, then rst asserted mid-clear -> all outputs to reset values asynchronously, clear restarts from 0.
